// File: rtl/pending_encoder.sv
// Sequential N-to-log2(N) encoder: captures request pulses into a pending register and
// streams their indices over valid/ready. Define PENDING_ENC_RR_EN for round-robin priority.
module pending_encoder #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   output logic [W-1:0] out_idx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] pending_o
);

   typedef enum logic [0:0] {StIdle, StPresent} state_e;

   state_e       state_q, state_d;
   logic [W-1:0] idx_q, idx_d;
   logic [N-1:0] pending_q, pending_d;
   logic [N-1:0] cand;
   logic [N-1:0] sel_mask;
   logic [W-1:0] sel_idx;
   logic [W-1:0] probe;
   logic [W-1:0] base;
   logic         sel_found;

   assign cand = pending_q | req_i;

`ifdef PENDING_ENC_RR_EN
   logic [W-1:0] ptr_q, ptr_d;
   assign base = ptr_q + W'(1);
`else
   assign base = '0;
`endif

   // N is a power of two, so the W-bit add wraps the search modulo N.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      probe     = '0;
      for (int i = 0; i < N; i++) begin
         probe = base + W'(i);
         if (!sel_found && cand[probe]) begin
            sel_found = 1'b1;
            sel_idx   = probe;
         end
      end
   end

   always_comb begin
      sel_mask          = '0;
      sel_mask[sel_idx] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = cand;
`ifdef PENDING_ENC_RR_EN
      ptr_d     = ptr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cand != '0) begin
               state_d   = StPresent;
               idx_d     = sel_idx;
               pending_d = cand & ~sel_mask;
`ifdef PENDING_ENC_RR_EN
               ptr_d     = sel_idx;
`endif
            end else begin
               pending_d = '0;
            end
         end
         StPresent: begin
            // On stall the presented index holds and new requests accumulate.
            if (out_ready) begin
               if (cand != '0) begin
                  idx_d     = sel_idx;
                  pending_d = cand & ~sel_mask;
`ifdef PENDING_ENC_RR_EN
                  ptr_d     = sel_idx;
`endif
               end else begin
                  state_d   = StIdle;
                  pending_d = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         pending_q <= '0;
`ifdef PENDING_ENC_RR_EN
         ptr_q     <= W'(N - 1);
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
`ifdef PENDING_ENC_RR_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign out_valid = (state_q == StPresent);
   assign out_idx   = idx_q;
   assign pending_o = pending_q;

endmodule

// File: tb/tb_pending_encoder.sv
// Self-checking bench for pending_encoder: a scoreboard queue of expected indices is checked
// on every accept, while each scenario task checks reset, hold and boundary behaviour inline.
module tb_pending_encoder;

   localparam int unsigned N = 8;
   localparam int unsigned W = 3;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req_i;
   logic [W-1:0] out_idx;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] pending_o;

   int tests_run;
   int tests_failed;
   int exp_q[$];

   pending_encoder #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_i),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pending_o (pending_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change at posedge+1, so a handshake seen at negedge completes on the next edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL scoreboard: unexpected index %0d accepted, none expected", out_idx);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (out_idx !== W'(e)) begin
               tests_failed++;
               $display("FAIL scoreboard: got index %0d, expected %0d", out_idx, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2;
      rst_n     = 1'b0;
      req_i     = '0;
      out_ready = 1'b0;
      exp_q.delete();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         tick();
         n++;
      end
      tests_run++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s drain: %0d indices left, out_valid=%b, expected 0 and 0",
                  name, exp_q.size(), out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_i     = 8'hFF;
      out_ready = 1'b1;
      repeat (2) tick();
      tests_run++;
      if ({out_valid, out_idx, pending_o} !== '0) begin
         tests_failed++;
         $display("FAIL reset_held: valid=%b idx=%0d pending=%h, expected 0 0 00",
                  out_valid, out_idx, pending_o);
      end
      req_i = '0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if ({out_valid, out_idx, pending_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: valid=%b idx=%0d pending=%h, expected 0 0 00",
                     out_valid, out_idx, pending_o);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      out_ready = 1'b1;
      req_i     = 8'h04;
      exp_q.push_back(2);
      tick();
      req_i = '0;
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== 3'd2) begin
         tests_failed++;
         $display("FAIL single_latency: valid=%b idx=%0d, expected 1 2", out_valid, out_idx);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_one_cycle: valid=%b, expected 0", out_valid);
      end
      wait_idle("single", 10);
   endtask

   task automatic test_multi();
      int seq[3] = '{1, 4, 7};
      do_reset();
      out_ready = 1'b1;
      req_i     = 8'h92;
      foreach (seq[k]) exp_q.push_back(seq[k]);
      tick();
      req_i = '0;
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if (out_valid !== 1'b1 || out_idx !== W'(seq[k])) begin
            tests_failed++;
            $display("FAIL multi_seq%0d: valid=%b idx=%0d, expected 1 %0d",
                     k, out_valid, out_idx, seq[k]);
         end
         tick();
      end
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL multi_end: valid=%b, expected 0", out_valid);
      end
      wait_idle("multi", 10);
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      req_i     = 8'h05;
      exp_q.push_back(0);
      exp_q.push_back(2);
      tick();
      req_i = '0;
      for (int c = 0; c < 5; c++) begin
         tests_run++;
         if (out_valid !== 1'b1 || out_idx !== 3'd0 || pending_o !== 8'h04) begin
            tests_failed++;
            $display("FAIL bp_hold%0d: valid=%b idx=%0d pending=%h, expected 1 0 04",
                     c, out_valid, out_idx, pending_o);
         end
         if (c < 4) tick();
      end
      out_ready = 1'b1;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== 3'd2) begin
         tests_failed++;
         $display("FAIL bp_release: valid=%b idx=%0d, expected 1 2", out_valid, out_idx);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || pending_o !== 8'h00) begin
         tests_failed++;
         $display("FAIL bp_idle: valid=%b pending=%h, expected 0 00", out_valid, pending_o);
      end
      wait_idle("backpressure", 10);
   endtask

   task automatic test_held_priority();
      do_reset();
      out_ready = 1'b1;
      req_i     = 8'h11;
`ifdef PENDING_ENC_RR_EN
      for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 0 : 4);
      exp_q.push_back(0);  // bit 0 left pending after the last grant of 4
`else
      for (int k = 0; k < 6; k++) exp_q.push_back(0);
      exp_q.push_back(4);  // bit 4 starved until the held request drops
`endif
      repeat (6) tick();
      req_i = '0;
      wait_idle("held_priority", 20);
   endtask

   task automatic test_all_bits();
      do_reset();
      out_ready = 1'b1;
      req_i     = 8'hFF;
      for (int k = 0; k < N; k++) exp_q.push_back(k);
      tick();
      req_i = '0;
      for (int k = 0; k < N; k++) begin
         tests_run++;
         if (out_valid !== 1'b1 || out_idx !== W'(k)) begin
            tests_failed++;
            $display("FAIL all_bits%0d: valid=%b idx=%0d, expected 1 %0d",
                     k, out_valid, out_idx, k);
         end
         tick();
      end
      wait_idle("all_bits", 10);
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      req_i     = 8'hF0;
      tick();
      req_i = '0;
      tests_run++;
      if (out_valid !== 1'b1 || out_idx !== 3'd4 || pending_o !== 8'hE0) begin
         tests_failed++;
         $display("FAIL mid_before: valid=%b idx=%0d pending=%h, expected 1 4 e0",
                  out_valid, out_idx, pending_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({out_valid, out_idx, pending_o} !== '0) begin
         tests_failed++;
         $display("FAIL mid_async_clear: valid=%b idx=%0d pending=%h, expected 0 0 00",
                  out_valid, out_idx, pending_o);
      end
      repeat (2) tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b0 || pending_o !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_after%0d: valid=%b pending=%h, expected 0 00",
                     c, out_valid, pending_o);
         end
      end
      wait_idle("reset_mid", 5);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      req_i        = '0;
      out_ready    = 1'b0;
      test_reset();
      test_single();
      test_multi();
      test_backpressure();
      test_held_priority();
      test_all_bits();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
